// File: rtl/factor_checker.sv
// Verifies factorFinder results: recomputes factorA*factorB with a 16-cycle shift-add
// multiplier and compares against product. Optional macro: FACTOR_CHECK_TRIVIAL_EN.
module factor_checker (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:31] product,
    input  logic [0:15] factorA,
    input  logic [0:15] factorB,
    input  logic        isDone,
    output logic        busy,
    output logic        checkDone,
    output logic        factorsValid,
    output logic [7:0]  passCount,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, MUL, CMP} state_t;

    state_t      state, stateNext;
    logic        isDoneQ;
    logic        trigger;
    logic        ok;
    logic [31:0] pReg;
    logic [31:0] acc;
    logic [15:0] aReg;
    logic [15:0] bReg;
    logic [4:0]  cnt;
`ifdef FACTOR_CHECK_TRIVIAL_EN
    // B is consumed by the multiplier, so the trivial-factor test is taken at capture
    logic        trivialQ;
`endif

    always_comb begin
        trigger   = isDone & ~isDoneQ;
        stateNext = state;
`ifdef FACTOR_CHECK_TRIVIAL_EN
        ok        = (acc == pReg) && !trivialQ;
`else
        ok        = (acc == pReg);
`endif
        case (state)
            IDLE:    if (trigger) stateNext = MUL;
            MUL:     if (cnt == 5'd15) stateNext = CMP;
            CMP:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            isDoneQ      <= 1'b0;
            busy         <= 1'b0;
            checkDone    <= 1'b0;
            factorsValid <= 1'b0;
            passCount    <= '0;
            overrun      <= 1'b0;
            pReg         <= '0;
            acc          <= '0;
            aReg         <= '0;
            bReg         <= '0;
            cnt          <= '0;
`ifdef FACTOR_CHECK_TRIVIAL_EN
            trivialQ     <= 1'b0;
`endif
        end else begin
            isDoneQ   <= isDone;
            checkDone <= 1'b0;
            if (trigger && busy) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        pReg <= product;
                        aReg <= factorA;
                        bReg <= factorB;
                        acc  <= '0;
                        cnt  <= '0;
                        busy <= 1'b1;
`ifdef FACTOR_CHECK_TRIVIAL_EN
                        trivialQ <= (factorA < 16'd2) || (factorB < 16'd2);
`endif
                    end
                end
                MUL: begin
                    if (bReg[0]) acc <= acc + ({16'b0, aReg} << cnt);
                    bReg <= bReg >> 1;
                    cnt  <= cnt + 5'd1;
                end
                CMP: begin
                    factorsValid <= ok;
                    checkDone    <= 1'b1;
                    busy         <= 1'b0;
                    if (ok && passCount != 8'hFF) passCount <= passCount + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_factor_checker.sv
// Bench for factor_checker: vector table plus hand sequences, verdicts checked
// against a scoreboard of expected results queued at trigger time.
module tb_factor_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:31] product;
    logic [0:15] factorA;
    logic [0:15] factorB;
    logic        isDone;
    logic        busy;
    logic        checkDone;
    logic        factorsValid;
    logic [7:0]  passCount;
    logic        overrun;

    factor_checker dut (
        .clk          (clk),
        .reset        (reset),
        .product      (product),
        .factorA      (factorA),
        .factorB      (factorB),
        .isDone       (isDone),
        .busy         (busy),
        .checkDone    (checkDone),
        .factorsValid (factorsValid),
        .passCount    (passCount),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

`ifdef FACTOR_CHECK_TRIVIAL_EN
    localparam bit TRIV = 1'b1;
`else
    localparam bit TRIV = 1'b0;
`endif

    typedef struct {
        logic [31:0] p;
        logic [15:0] a;
        logic [15:0] b;
        logic        vPlain;
        logic        vTriv;
    } vec_t;

    typedef struct {
        logic       valid;
        logic [7:0] pc;
        int         cyc;
    } exp_t;

    vec_t       vecs[13];
    exp_t       sbq[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         doneCount = 0;
    int         d0;
    logic [7:0] expPc = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (checkDone) begin
            doneCount++;
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_checkDone: got pulse at cycle %0d expected none", cyc);
            end else begin
                e = sbq.pop_front();
                chk("factorsValid", factorsValid, e.valid);
                chk("passCount", passCount, e.pc);
                chk("latency", cyc, e.cyc);
                chk("busy_at_done", busy, 0);
            end
        end
    endtask

    task automatic pushExp(input logic v);
        exp_t e;
        if (v && expPc != 8'hFF) expPc++;
        e.valid = v;
        e.pc    = expPc;
        e.cyc   = cyc + 18;
        sbq.push_back(e);
    endtask

    task automatic startCheck(input logic [31:0] p, input logic [15:0] a, input logic [15:0] b,
                              input logic v, input bit push);
        product = p;
        factorA = a;
        factorB = b;
        isDone  = 1'b1;
        if (push) pushExp(v);
        tick();
        isDone = 1'b0;
        chk("busy_after_trigger", busy, 1);
    endtask

    task automatic runCheck(input logic [31:0] p, input logic [15:0] a, input logic [15:0] b,
                            input logic v);
        startCheck(p, a, b, v, 1'b1);
        repeat (19) tick();
    endtask

    initial begin
        vecs[0]  = '{32'd143,        16'd11,     16'd13,     1'b1, 1'b1};
        vecs[1]  = '{32'd143,        16'd1,      16'd143,    1'b1, 1'b0};
        vecs[2]  = '{32'd143,        16'd15,     16'd13,     1'b0, 1'b0};
        vecs[3]  = '{32'hFFFE0001,   16'hFFFF,   16'hFFFF,   1'b1, 1'b1};
        vecs[4]  = '{32'd35,         16'd5,      16'd7,      1'b1, 1'b1};
        vecs[5]  = '{32'd35,         16'd7,      16'd5,      1'b1, 1'b1};
        vecs[6]  = '{32'd0,          16'd0,      16'd5,      1'b1, 1'b0};
        vecs[7]  = '{32'd0,          16'd3,      16'd0,      1'b1, 1'b0};
        vecs[8]  = '{32'd0,          16'd3,      16'd5,      1'b0, 1'b0};
        vecs[9]  = '{32'd36,         16'd6,      16'd6,      1'b1, 1'b1};
        vecs[10] = '{32'd37,         16'd37,     16'd1,      1'b1, 1'b0};
        vecs[11] = '{32'h0001FFFE,   16'd2,      16'hFFFF,   1'b1, 1'b1};
        vecs[12] = '{32'd1000,       16'd0,      16'd0,      1'b0, 1'b0};

        reset   = 1'b1;
        isDone  = 1'b0;
        product = '0;
        factorA = '0;
        factorB = '0;
        repeat (3) tick();
        chk("reset_busy", busy, 0);
        chk("reset_checkDone", checkDone, 0);
        chk("reset_factorsValid", factorsValid, 0);
        chk("reset_passCount", passCount, 0);
        chk("reset_overrun", overrun, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 13; i++)
            runCheck(vecs[i].p, vecs[i].a, vecs[i].b, TRIV ? vecs[i].vTriv : vecs[i].vPlain);
        chk("overrun_after_table", overrun, 0);

        // isDone held high: only the rising edge triggers
        d0      = doneCount;
        product = 32'd35;
        factorA = 16'd5;
        factorB = 16'd7;
        isDone  = 1'b1;
        pushExp(1'b1);
        repeat (60) tick();
        isDone = 1'b0;
        repeat (3) tick();
        chk("held_high_pulses", doneCount - d0, 1);
        chk("held_high_overrun", overrun, 0);

        // second rising edge at E5 with garbage operands
        startCheck(32'd143, 16'd11, 16'd13, 1'b1, 1'b1);
        repeat (4) tick();
        product = 32'd5;
        factorA = 16'd3;
        factorB = 16'd3;
        isDone  = 1'b1;
        tick();
        chk("overrun_set", overrun, 1);
        isDone = 1'b0;
        repeat (14) tick();
        chk("overrun_sticky", overrun, 1);
        runCheck(32'd35, 16'd5, 16'd7, 1'b1);
        chk("overrun_sticky_later", overrun, 1);

        for (int i = 0; i < 260; i++)
            runCheck(32'd143, 16'd11, 16'd13, 1'b1);
        chk("passCount_saturated", passCount, 8'hFF);

        // reset sampled at E8 of an in-flight check
        startCheck(32'd35, 16'd5, 16'd7, 1'b1, 1'b0);
        repeat (7) tick();
        reset = 1'b1;
        tick();
        chk("midreset_busy", busy, 0);
        chk("midreset_checkDone", checkDone, 0);
        chk("midreset_factorsValid", factorsValid, 0);
        chk("midreset_passCount", passCount, 0);
        chk("midreset_overrun", overrun, 0);
        reset = 1'b0;
        expPc = '0;
        d0    = doneCount;
        repeat (25) tick();
        chk("aborted_no_pulse", doneCount - d0, 0);
        runCheck(32'd35, 16'd5, 16'd7, 1'b1);
        chk("post_reset_valid", factorsValid, 1);

        chk("pending_verdicts", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
